// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master port FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_PIPE = 3'd2,
        ST_LAST = 3'd3,
        ST_ERR2 = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/ahb_master_port.sv
// Single-channel AHB master: one SINGLE or INCR4 command becomes a pipelined
// transfer sequence; the result comes back on a one-cycle response strobe.
module ahb_master_port
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic                cmd_burst,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [4*DATA_W-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [4*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   haddr,
    output logic [1:0]          htrans,
    output logic                hwrite,
    output logic [2:0]          hsize,
    output logic [2:0]          hburst,
    output logic [3:0]          hprot,
    output logic                hmastlock,
    output logic [DATA_W-1:0]   hwdata,
    input  logic [DATA_W-1:0]   hrdata,
    input  logic                hready,
    input  logic [1:0]          hresp
);

    localparam logic [ADDR_W-1:0] MASK_WORD  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] MASK_BURST = ~ADDR_W'(15);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [1:0]          abeat_q, abeat_d;
    logic [1:0]          dbeat_q, dbeat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                wr_q, wr_d;
    logic                burst_q, burst_d;
    logic                err_q, err_d;
    logic [4*DATA_W-1:0] wdata_q, wdata_d;
    logic [4*DATA_W-1:0] rdata_q, rdata_d;

    logic data_phase;
    logic err_first;

    assign data_phase = (state_q == ST_PIPE) || (state_q == ST_LAST);
    // First cycle of a two-cycle non-OKAY response; RETRY/SPLIT count as ERROR.
    assign err_first  = data_phase && !hready && (hresp != HRESP_OKAY);

    always_comb begin
        state_d = state_q;
        abeat_d = abeat_q;
        dbeat_d = dbeat_q;
        base_d  = base_q;
        wr_d    = wr_q;
        burst_d = burst_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    wr_d    = cmd_write;
                    burst_d = cmd_burst;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    abeat_d = 2'd0;
                    dbeat_d = 2'd0;
                    base_d  = cmd_addr & (cmd_burst ? MASK_BURST : MASK_WORD);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    if (burst_q) begin
                        abeat_d = 2'd1;
                        state_d = ST_PIPE;
                    end else begin
                        state_d = ST_LAST;
                    end
                end
            end
            ST_PIPE, ST_LAST: begin
                if (err_first) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR2;
                end else if (hready) begin
                    if (hresp == HRESP_OKAY) begin
                        if (!wr_q)
                            rdata_d[int'(dbeat_q)*DATA_W +: DATA_W] = hrdata;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (state_q == ST_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        dbeat_d = dbeat_q + 2'd1;
                        if (abeat_q == 2'd3)
                            state_d = ST_LAST;
                        else
                            abeat_d = abeat_q + 2'd1;
                    end
                end
            end
            ST_ERR2: begin
                if (hready)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            abeat_q <= 2'd0;
            dbeat_q <= 2'd0;
            base_q  <= '0;
            wr_q    <= 1'b0;
            burst_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            abeat_q <= abeat_d;
            dbeat_q <= dbeat_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_ADDR: htrans = HTRANS_NONSEQ;
            ST_PIPE: htrans = err_first ? HTRANS_IDLE : HTRANS_SEQ;
            default: htrans = HTRANS_IDLE;
        endcase
    end

    assign cmd_ready = ready_q;
    assign haddr     = base_q | ADDR_W'({abeat_q, 2'b00});
    assign hwrite    = wr_q;
    assign hburst    = burst_q ? HBURST_INCR4 : HBURST_SINGLE;
    assign hsize     = HSIZE_WORD;
    assign hprot     = HPROT_DEFAULT;
    assign hmastlock = 1'b0;
    assign hwdata    = wdata_q[int'(dbeat_q)*DATA_W +: DATA_W];
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_err   = (state_q == ST_DONE) && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port: scripted AHB slave with memory, directed plus
// random commands, results predicted from burst/wait/error rules.
module tb_ahb_master_port;
    import ahb_pkg::*;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         cmd_valid = 1'b0, cmd_write = 1'b0, cmd_burst = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [127:0] cmd_wdata = '0;
    logic         cmd_ready, rsp_valid, rsp_err;
    logic [127:0] rsp_rdata;
    logic [31:0]  haddr, hwdata;
    logic [31:0]  hrdata = '0;
    logic [1:0]   htrans;
    logic [1:0]   hresp = HRESP_OKAY;
    logic         hwrite, hmastlock;
    logic         hready = 1'b1;
    logic [2:0]   hsize, hburst;
    logic [3:0]   hprot;

    always #5 HCLK = ~HCLK;

    ahb_master_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  burst;
    } aph_t;

    int           tests = 0, fails = 0, cyc = 0;
    logic [31:0]  mem [0:1023];
    int           sc_wait [4];
    int           sc_err = -1;
    aph_t         aph_q[$];
    int           acc_q[$];
    int           rsp_q[$];
    logic [127:0] rsp_data_q[$];
    logic         rsp_err_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #2;
        end
    endtask

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    // Slave: drives at the falling edge, samples the master 1 ns later.
    initial begin
        bit          dp, dpw, err_pend, hold_chk, wd_chk;
        int          wl, est, bidx;
        logic [31:0] dpa;
        logic        p_rst, p_rdy, p_wr;
        logic [1:0]  p_resp, p_trans;
        logic [31:0] p_addr, p_wdata;
        dp = 0; dpw = 0; err_pend = 0; wl = 0; est = 0; bidx = 0; dpa = '0;
        p_rst = 0; p_rdy = 1; p_wr = 0; p_resp = HRESP_OKAY; p_trans = HTRANS_IDLE;
        p_addr = '0; p_wdata = '0; hold_chk = 0; wd_chk = 0;
        forever begin
            @(negedge HCLK);
            if (!p_rst) begin
                dp = 0; est = 0; bidx = 0; wl = 0; err_pend = 0;
            end else begin
                if (dp && p_rdy && p_resp == HRESP_OKAY && dpw)
                    mem[dpa[11:2]] = p_wdata;
                if (p_rdy) begin
                    dp = p_trans[1];
                    if (dp) begin
                        dpa = p_addr;
                        dpw = p_wr;
                        if (p_trans == HTRANS_NONSEQ) bidx = 0;
                        wl       = (bidx < 4) ? sc_wait[bidx] : 0;
                        err_pend = (bidx == sc_err);
                        est      = 0;
                        bidx++;
                    end
                end
            end
            hresp  = HRESP_OKAY;
            hready = 1'b1;
            hrdata = $urandom;
            if (dp) begin
                if (wl > 0) begin
                    hready = 1'b0;
                    wl--;
                end else if (err_pend) begin
                    hresp  = HRESP_ERROR;
                    hready = (est == 1);
                    est++;
                end else if (!dpw) begin
                    hrdata = mem[dpa[11:2]];
                end
            end
            #1;
            if (hold_chk && hresp == HRESP_OKAY) begin
                chk("hold_haddr", haddr, p_addr);
                chk("hold_htrans", htrans, p_trans);
                chk("hold_hwrite", hwrite, p_wr);
            end
            if (wd_chk && hresp == HRESP_OKAY)
                chk("hold_hwdata", hwdata, p_wdata);
            if (HRESETn && dp && hresp != HRESP_OKAY && !hready)
                chk("err_htrans_idle", htrans, HTRANS_IDLE);
            if (HRESETn && htrans[1] && hready)
                aph_q.push_back('{cyc, haddr, htrans, hwrite, hburst});
            hold_chk = HRESETn && htrans[1] && !hready && hresp == HRESP_OKAY;
            wd_chk   = HRESETn && dp && dpw && !hready && hresp == HRESP_OKAY;
            p_rst = HRESETn; p_rdy = hready; p_resp = hresp; p_trans = htrans;
            p_addr = haddr; p_wr = hwrite; p_wdata = hwdata;
        end
    end

    initial forever begin
        @(negedge HCLK);
        #2;
        if (HRESETn && cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid) begin
            rsp_q.push_back(cyc);
            rsp_data_q.push_back(rsp_rdata);
            rsp_err_q.push_back(rsp_err);
        end
    end

    task automatic clear_logs();
        aph_q.delete(); acc_q.delete(); rsp_q.delete();
        rsp_data_q.delete(); rsp_err_q.delete();
    endtask

    // eb = beat index answered with ERROR, or -1 for none.
    task automatic do_cmd(input string tag, input bit wr, input bit bst, input logic [31:0] addr,
                          input logic [127:0] wd, input int w0, input int w1, input int w2,
                          input int w3, input int eb);
        int           n, na, nc, ws, lat;
        int           wv [4];
        logic [31:0]  base;
        logic [31:0]  old [4];
        logic [127:0] exp_rd;
        wv = '{w0, w1, w2, w3};
        n    = bst ? 4 : 1;
        base = bst ? (addr & ~32'hF) : (addr & ~32'h3);
        na   = (eb >= 0) ? eb + 1 : n;
        nc   = (eb >= 0) ? eb : n;
        ws   = 0;
        for (int k = 0; k < na; k++) ws += wv[k];
        lat  = 2 + na + ws + ((eb >= 0) ? 1 : 0);
        exp_rd = '0;
        for (int k = 0; k < 4; k++) begin
            old[k] = mem[((base >> 2) + k) & 1023];
            if (!wr && k < nc) exp_rd[32*k +: 32] = old[k];
        end
        clear_logs();
        sc_wait = wv;
        sc_err  = eb;
        cmd_write = wr; cmd_burst = bst; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) tick(1);
        cmd_valid = 1'b0;
        chk({tag, "_accept"}, acc_q.size(), 1);
        for (int i = 0; i < 60 && rsp_q.size() == 0; i++) tick(1);
        tick(2);
        chk({tag, "_rsp_count"}, rsp_q.size(), 1);
        if (rsp_q.size() > 0 && acc_q.size() > 0) begin
            chk({tag, "_latency"}, rsp_q[0] - acc_q[0], lat);
            chk({tag, "_rsp_err"}, rsp_err_q[0], (eb >= 0));
            if (!wr) begin
                chk({tag, "_rdata"}, rsp_data_q[0], exp_rd);
                chk({tag, "_rdata_stable"}, rsp_rdata, exp_rd);
            end
        end
        chk({tag, "_addr_phases"}, aph_q.size(), na);
        for (int k = 0; k < aph_q.size() && k < na; k++) begin
            chk({tag, "_haddr"}, aph_q[k].addr, base + 32'(4 * k));
            chk({tag, "_htrans"}, aph_q[k].trans, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            chk({tag, "_hwrite"}, aph_q[k].wr, wr);
            chk({tag, "_hburst"}, aph_q[k].burst, bst ? HBURST_INCR4 : HBURST_SINGLE);
        end
        if (aph_q.size() > 0 && acc_q.size() > 0)
            chk({tag, "_nonseq_cycle"}, aph_q[0].cyc - acc_q[0], 1);
        if (wr)
            for (int k = 0; k < n; k++)
                chk({tag, "_mem"}, mem[((base >> 2) + k) & 1023], (k < nc) ? wd[32*k +: 32] : old[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit           wr, bst;
        int           eb;
        logic [31:0]  a1, a2;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[32'h200 >> 2] = 32'h11; mem[32'h204 >> 2] = 32'h22;
        mem[32'h208 >> 2] = 32'h33; mem[32'h20C >> 2] = 32'h44;
        sc_wait = '{0, 0, 0, 0};

        tick(1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_htrans", htrans, HTRANS_IDLE);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_hsize", hsize, 3'b010);
        chk("rst_hprot", hprot, 4'b0011);
        chk("rst_hmastlock", hmastlock, 0);
        tick(2);
        HRESETn = 1'b1;
        tick(1);
        chk("rel_cmd_ready", cmd_ready, 1);

        do_cmd("single_wr", 1, 0, 32'h100, 128'hDEADBEEF, 0, 0, 0, 0, -1);
        do_cmd("incr4_rd", 0, 1, 32'h204, '0, 0, 2, 0, 0, -1);
        do_cmd("incr4_wr_err", 1, 1, 32'h340, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 0, 0, 0, 0, 2);
        do_cmd("unaligned", 0, 0, 32'h103, '0, 0, 0, 0, 0, -1);
        if (aph_q.size() > 0) chk("unaligned_haddr", aph_q[0].addr, 32'h100);
        do_cmd("single_rd_err_wait", 0, 0, 32'h3F8, '0, 2, 0, 0, 0, 0);

        // Reset during the beat-1 data phase of an INCR4 read.
        clear_logs();
        sc_wait = '{0, 6, 0, 0};
        sc_err  = -1;
        cmd_write = 0; cmd_burst = 1; cmd_addr = 32'h300; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) tick(1);
        cmd_valid = 1'b0;
        tick(2);
        HRESETn = 1'b0;
        tick(1);
        chk("midrst_htrans", htrans, HTRANS_IDLE);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        chk("midrst_rel_ready", cmd_ready, 1);
        tick(2);
        chk("midrst_no_rsp", rsp_q.size(), 0);

        // Back-to-back SINGLE reads with cmd_valid held high.
        clear_logs();
        sc_wait = '{0, 0, 0, 0};
        a1 = 32'h050; a2 = 32'h0A4;
        cmd_write = 0; cmd_burst = 0; cmd_addr = a1; cmd_valid = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) tick(1);
        cmd_addr = a2;
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) tick(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && rsp_q.size() < 2; i++) tick(1);
        chk("b2b_rsp_count", rsp_q.size(), 2);
        chk("b2b_acc_count", acc_q.size(), 2);
        if (rsp_q.size() == 2 && acc_q.size() == 2) begin
            chk("b2b_accept_gap", acc_q[1] - rsp_q[0], 1);
            chk("b2b_rdata0", rsp_data_q[0], {96'd0, mem[a1 >> 2]});
            chk("b2b_rdata1", rsp_data_q[1], {96'd0, mem[a2 >> 2]});
        end
        chk("b2b_aph_count", aph_q.size(), 2);
        if (aph_q.size() == 2)
            chk("b2b_nonseq_gap", aph_q[1].cyc - aph_q[0].cyc, 4);
        tick(2);

        for (int t = 0; t < 14; t++) begin
            wr  = 1'($urandom_range(0, 1));
            bst = 1'($urandom_range(0, 1));
            eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bst ? 3 : 0) : -1;
            do_cmd("rand", wr, bst, 32'($urandom_range(0, 4095)),
                   {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2), eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
